pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Each stage resolves WIDTH/STAGES sum bits and passes the carry and the unresolved operand bits on.
module pipelined_cla_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);
   localparam int SLICE = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;
   localparam logic [STAGES-1:0] ALL_ONES = '1;

   // Per-stage registers: x holds resolved sum bits below the boundary and raw a bits above it.
   logic [WIDTH-1:0]  x_q [STAGES];
   logic [WIDTH-1:0]  x_d [STAGES];
   logic [WIDTH-1:0]  y_q [STAGES];
   logic [WIDTH-1:0]  y_d [STAGES];
   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [STAGES-1:0] as_q, as_d;
   logic [STAGES-1:0] bs_q, bs_d;

   // Stage sources: stage 0 reads the ports, stage k reads stage k-1.
   logic [WIDTH-1:0]  src_x [STAGES];
   logic [WIDTH-1:0]  src_y [STAGES];
   logic [STAGES-1:0] src_c, src_as, src_bs, src_v;
   logic [SLICE:0]    res [STAGES];
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  b_eff;

   function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y,
                                                input logic             cin);
      logic [SLICE-1:0] g, p, sum;
      logic [3:0]       gg, pp;
      logic [4:0]       gc;
      logic             c;
      g   = x & y;
      p   = x ^ y;
      c   = cin;
      sum = '0;
      for (int grp = 0; grp < SLICE / 4; grp++) begin
         gg    = g[grp*4 +: 4];
         pp    = p[grp*4 +: 4];
         gc[0] = c;
         gc[1] = gg[0] | (pp[0] & c);
         gc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
         gc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c);
         gc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & c);
         sum[grp*4 +: 4] = pp ^ gc[3:0];
         c = gc[4];
      end
      return {c, sum};
   endfunction

   assign b_eff = sub ? ~b : b;

   // A stage may advance when it or any stage downstream of it holds a bubble, or the output drains.
   always_comb begin
      adv = '0;
      for (int k = 0; k < STAGES; k++) begin
         adv[k] = out_ready | (|(~vld_q & (ALL_ONES << k)));
      end
   end

   always_comb begin
      src_x[0]  = a;
      src_y[0]  = b_eff;
      src_c[0]  = sub | ci;
      src_as[0] = a[WIDTH-1];
      src_bs[0] = b_eff[WIDTH-1];
      src_v[0]  = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         src_x[k]  = x_q[k-1];
         src_y[k]  = y_q[k-1];
         src_c[k]  = c_q[k-1];
         src_as[k] = as_q[k-1];
         src_bs[k] = bs_q[k-1];
         src_v[k]  = vld_q[k-1];
      end
   end

   // NOTE: every always_comb output gets a hold-value default first so no path infers a latch.
   always_comb begin
      vld_d = vld_q;
      c_d   = c_q;
      as_d  = as_q;
      bs_d  = bs_q;
      for (int k = 0; k < STAGES; k++) begin
         x_d[k] = x_q[k];
         y_d[k] = y_q[k];
         res[k] = cla_slice(src_x[k][k*SLICE +: SLICE], src_y[k][k*SLICE +: SLICE], src_c[k]);
         if (adv[k]) begin
            vld_d[k] = src_v[k];
         end
         if (adv[k] && src_v[k]) begin
            x_d[k]                  = src_x[k];
            x_d[k][k*SLICE +: SLICE] = res[k][SLICE-1:0];
            y_d[k]                  = src_y[k];
            c_d[k]                  = res[k][SLICE];
            as_d[k]                 = src_as[k];
            bs_d[k]                 = src_bs[k];
         end
      end
   end

   // NOTE: state updates use non-blocking assignments; data registers are reset too so s/co/ovf read 0 during reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         c_q   <= '0;
         as_q  <= '0;
         bs_q  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         c_q   <= c_d;
         as_q  <= as_d;
         bs_q  <= bs_d;
         for (int k = 0; k < STAGES; k++) begin
            x_q[k] <= x_d[k];
            y_q[k] <= y_d[k];
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = vld_q[LAST];
   assign s         = x_q[LAST];
   assign co        = c_q[LAST];
   assign ovf       = (as_q[LAST] == bs_q[LAST]) && (x_q[LAST][WIDTH-1] != as_q[LAST]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: a 32-bit two-stage instance and a 16-bit single-stage instance.
module tb_pipelined_cla_adder;
   logic        clk;
   logic        reset_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, s;
   logic        ci, sub, co, ovf;

   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic [15:0] h_a, h_b, h_s;
   logic        h_ci, h_sub, h_co, h_ovf;

   int checks = 0;
   int errors = 0;

   pipelined_cla_adder #(.WIDTH(32), .STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ovf(ovf)
   );

   pipelined_cla_adder #(.WIDTH(16), .STAGES(1)) dut16 (
      .clk(clk), .reset_n(reset_n),
      .in_valid(h_in_valid), .in_ready(h_in_ready),
      .a(h_a), .b(h_b), .ci(h_ci), .sub(h_sub),
      .out_valid(h_out_valid), .out_ready(h_out_ready),
      .s(h_s), .co(h_co), .ovf(h_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                        input logic civ, input logic subv);
      in_valid = v;
      a        = av;
      b        = bv;
      ci       = civ;
      sub      = subv;
   endtask

   // Single operation through the empty two-stage pipe, checked two cycles after acceptance.
   task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic civ, input logic subv,
                          input logic [31:0] exp_s, input logic exp_co, input logic exp_ovf);
      drive(1'b1, av, bv, civ, subv);
      check({tag, ".in_ready"}, in_ready, 1);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check({tag, ".lat1_valid"}, out_valid, 0);
      step();
      check({tag, ".valid"}, out_valid, 1);
      check({tag, ".s"}, s, exp_s);
      check({tag, ".co"}, co, exp_co);
      check({tag, ".ovf"}, ovf, exp_ovf);
      step();
      check({tag, ".drained"}, out_valid, 0);
   endtask

   initial begin
      int  sent;
      int  recv;
      logic fin, fout;

      reset_n     = 1'b0;
      out_ready   = 1'b1;
      h_out_ready = 1'b1;
      h_in_valid  = 1'b0;
      h_a         = '0;
      h_b         = '0;
      h_ci        = 1'b0;
      h_sub       = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      #3;
      check("reset.out_valid", out_valid, 0);
      check("reset.in_ready", in_ready, 1);
      check("reset.s", s, 0);
      check("reset.co", co, 0);
      check("reset.ovf", ovf, 0);
      check("reset.h_out_valid", h_out_valid, 0);
      check("reset.h_in_ready", h_in_ready, 1);
      #9 reset_n = 1'b1;
      step();

      run_one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

      // Back-to-back: positive overflow, then carry crossing the stage boundary.
      drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("ovf_add.valid", out_valid, 1);
      check("ovf_add.s", s, 32'h8000_0000);
      check("ovf_add.co", co, 0);
      check("ovf_add.ovf", ovf, 1);
      step();
      check("cross.valid", out_valid, 1);
      check("cross.s", s, 32'h0001_0000);
      check("cross.co", co, 0);
      check("cross.ovf", ovf, 0);
      step();
      check("cross.drained", out_valid, 0);

      run_one("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_one("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Six adds i+i with the output stalled in cycles 2..5.
      sent = 0;
      recv = 0;
      for (int cyc = 1; cyc <= 40 && recv < 6; cyc++) begin
         out_ready = !(cyc >= 2 && cyc <= 5);
         drive(sent < 6, 32'(sent + 1), 32'(sent + 1), 1'b0, 1'b0);
         #1;
         if (cyc == 3) check("stall.in_ready_full", in_ready, 0);
         if (out_valid) check("stall.s_head", s, 64'(2 * (recv + 1)));
         fin  = in_valid && in_ready;
         fout = out_valid && out_ready;
         step();
         if (fin) sent++;
         if (fout) recv++;
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      out_ready = 1'b1;
      check("stall.sent", 64'(sent), 6);
      check("stall.recv", 64'(recv), 6);
      check("stall.no_dup", out_valid, 0);

      // Asynchronous reset with two operations in flight.
      drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("flush.pre_valid", out_valid, 1);
      check("flush.pre_s", s, 7);
      #2 reset_n = 1'b0;
      #1;
      check("flush.out_valid", out_valid, 0);
      check("flush.s", s, 0);
      check("flush.co", co, 0);
      check("flush.in_ready", in_ready, 1);
      #2 reset_n = 1'b1;
      drive(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("flush.no_stale", out_valid, 0);
      step();
      check("flush.first_valid", out_valid, 1);
      check("flush.first_s", s, 32'h3333_3333);
      step();
      check("flush.drained", out_valid, 0);

      // Single-stage 16-bit instance.
      h_in_valid = 1'b1;
      h_a        = 16'hABCD;
      h_b        = 16'h1234;
      h_ci       = 1'b1;
      check("w16.in_ready", h_in_ready, 1);
      step();
      h_in_valid = 1'b0;
      check("w16.valid", h_out_valid, 1);
      check("w16.s", h_s, 16'hBE02);
      check("w16.co", h_co, 0);
      check("w16.ovf", h_ovf, 0);
      step();
      check("w16.drained", h_out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
